// File: rtl/tetris_game_sequencer.sv
// Game-level sequencer: state bus, LFSR piece pick, gravity timer,
// full-row counting on lock, saturating lines total and game over.
module tetris_game_sequencer #(
  parameter int          DROP_DIV  = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clka,
  input  logic        restart,
  input  logic        start,
  input  logic [31:0] board,
  input  logic        landed,
  input  logic        clear_error,
  output logic [2:0]  state,
  output logic [1:0]  curr_piece,
  output logic        spawn,
  output logic        drop,
  output logic [7:0]  lines,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_GEN    = 3'b000,
    S_MOVING = 3'b001,
    S_LOCK   = 3'b010,
    S_CLEAR  = 3'b011,
    S_OVER   = 3'b100,
    S_IDLE   = 3'b101
  } state_t;

  localparam int CW = (DROP_DIV > 1) ? $clog2(DROP_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DROP_DIV - 1);

  state_t        r_state;
  logic [7:0]    r_lfsr;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_full;
  logic [1:0]    r_piece;
  logic          r_spawn;
  logic          r_drop;
  logic [7:0]    r_lines;
  logic          r_over;

  logic [3:0]    w_full;
  logic [8:0]    w_sum;
  logic          w_top_clear;
  logic          w_fb;

  assign w_top_clear = (board[31:28] == 4'h0);
  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_sum = {1'b0, r_lines} + {5'b0, r_full};

  // count rows of the committed board that are completely filled
  always_comb begin
    w_full = 4'd0;
    for (int r = 0; r < 8; r++) begin
      if (board[4*r +: 4] == 4'hF) w_full = w_full + 4'd1;
    end
  end

  // main game FSM; every output is a register updated here
  always_ff @(posedge clka) begin
    if (restart) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_cnt   <= '0;
      r_full  <= 4'd0;
      r_piece <= 2'd0;
      r_spawn <= 1'b0;
      r_drop  <= 1'b0;
      r_lines <= 8'd0;
      r_over  <= 1'b0;
    end else begin
      r_drop  <= 1'b0;
      r_spawn <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_state <= S_GEN;
            r_lines <= 8'd0;
            r_over  <= 1'b0;
            r_spawn <= w_top_clear;
          end
        end
        S_GEN: begin
          if (!w_top_clear) begin
            r_state <= S_OVER;
            r_over  <= 1'b1;
          end else begin
            r_piece <= r_lfsr[1:0];
            r_lfsr  <= {r_lfsr[6:0], w_fb};
            r_cnt   <= '0;
            r_state <= S_MOVING;
          end
        end
        S_MOVING: begin
          if (landed) begin
            r_state <= S_LOCK;
          end else if (r_cnt == CNT_TOP) begin
            r_cnt  <= '0;
            r_drop <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOCK: begin
          r_full  <= w_full;
          r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          if (clear_error) begin
            r_state <= S_OVER;
            r_over  <= 1'b1;
          end else begin
            r_lines <= w_sum[8] ? 8'hFF : w_sum[7:0];
            r_state <= S_GEN;
            r_spawn <= w_top_clear;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign curr_piece = r_piece;
  assign spawn      = r_spawn;
  assign drop       = r_drop;
  assign lines      = r_lines;
  assign game_over  = r_over;

endmodule

// File: tb/tb_tetris_game_sequencer.sv
// Directed bench for tetris_game_sequencer with a piece scoreboard
// and an LFSR / lines reference model.
module tb_tetris_game_sequencer;

  logic        clka = 1'b0;
  logic        restart;
  logic        start;
  logic [31:0] board;
  logic        landed;
  logic        clear_error;
  logic [2:0]  state;
  logic [1:0]  curr_piece;
  logic        spawn;
  logic        drop;
  logic [7:0]  lines;
  logic        game_over;

  localparam logic [2:0] GEN = 3'b000, MOV = 3'b001, LCK = 3'b010;
  localparam logic [2:0] CLR = 3'b011, OVR = 3'b100, IDL = 3'b101;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_lfsr;
  int m_lines;
  logic [1:0] q_piece[$];

  tetris_game_sequencer #(.DROP_DIV(4), .LFSR_SEED(8'hA5)) dut (
    .clka(clka), .restart(restart), .start(start), .board(board),
    .landed(landed), .clear_error(clear_error), .state(state),
    .curr_piece(curr_piece), .spawn(spawn), .drop(drop),
    .lines(lines), .game_over(game_over)
  );

  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_piece();
    q_piece.push_back(m_lfsr[1:0]);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic pop_piece(input string tag);
    logic [1:0] e;
    if (q_piece.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=none expected=queued piece", tag);
    end else begin
      e = q_piece.pop_front();
      chk(tag, 32'(curr_piece), 32'(e));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(IDL));
    chk({tag, "_piece"}, 32'(curr_piece), 32'd0);
    chk({tag, "_spawn"}, 32'(spawn), 32'd0);
    chk({tag, "_drop"}, 32'(drop), 32'd0);
    chk({tag, "_lines"}, 32'(lines), 32'd0);
    chk({tag, "_over"}, 32'(game_over), 32'd0);
  endtask

  task automatic start_game(input string tag);
    start = 1'b1;
    board = 32'h0;
    tick();
    start = 1'b0;
    chk({tag, "_gen"}, 32'(state), 32'(GEN));
    chk({tag, "_spawn"}, 32'(spawn), 32'd1);
    chk({tag, "_lines0"}, 32'(lines), 32'd0);
    push_piece();
    m_lines = 0;
    tick();
    chk({tag, "_mov"}, 32'(state), 32'(MOV));
    pop_piece({tag, "_piece"});
  endtask

  // from MOVING: lock with board b, then return to MOVING via GEN
  task automatic lock_cycle(input string tag, input logic [31:0] b,
                            input int nfull);
    board = b;
    landed = 1'b1;
    tick();
    landed = 1'b0;
    chk({tag, "_lock"}, 32'(state), 32'(LCK));
    chk({tag, "_ldrop"}, 32'(drop), 32'd0);
    tick();
    chk({tag, "_clear"}, 32'(state), 32'(CLR));
    tick();
    m_lines = m_lines + nfull;
    if (m_lines > 255) m_lines = 255;
    chk({tag, "_gen"}, 32'(state), 32'(GEN));
    chk({tag, "_lines"}, 32'(lines), 32'(m_lines));
    chk({tag, "_spawn"}, 32'(spawn), 32'd1);
    push_piece();
    tick();
    chk({tag, "_mov"}, 32'(state), 32'(MOV));
    pop_piece({tag, "_piece"});
  endtask

  initial begin
    restart = 1'b1;
    start = 1'b0;
    board = 32'h0;
    landed = 1'b0;
    clear_error = 1'b0;
    m_lfsr = 8'hA5;
    m_lines = 0;
    tick();
    tick();
    chk_reset("rst");
    restart = 1'b0;
    tick();
    chk("idle_hold", 32'(state), 32'(IDL));

    // first piece from seed A5 is 2'b01
    chk("seed_model", 32'(m_lfsr[1:0]), 32'd1);
    start_game("t1");

    // gravity: drop on MOVING cycles 5, 9, 13 only
    for (int c = 2; c <= 13; c++) begin
      tick();
      chk($sformatf("t2_drop_c%0d", c), 32'(drop),
          32'((c == 5 || c == 9 || c == 13) ? 1 : 0));
    end

    // second piece from lfsr 4A is 2'b10
    chk("lfsr_4a_model", 32'(m_lfsr[1:0]), 32'd2);
    lock_cycle("t3a", 32'h0BAFFDCD, 2);
    lock_cycle("t3b", 32'h0BADCDAA, 0);

    // start ignored while MOVING
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ign", 32'(state), 32'(MOV));

    // now MOVING cycle 2; reach terminal count cycle 4 then land
    tick();
    tick();
    chk("t5_pre_drop", 32'(drop), 32'd0);
    board = 32'h0BAFFDCD;
    landed = 1'b1;
    tick();
    landed = 1'b0;
    chk("t5_land_state", 32'(state), 32'(LCK));
    chk("t5_land_drop", 32'(drop), 32'd0);
    tick();
    chk("t5_clear", 32'(state), 32'(CLR));
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    chk("t5_over", 32'(state), 32'(OVR));
    chk("t5_gameover", 32'(game_over), 32'd1);
    chk("t5_lines_held", 32'(lines), 32'(m_lines));
    tick();
    chk("t5_over_hold", 32'(state), 32'(OVR));
    start_game("t5r");

    // game over at spawn: top row occupied
    landed = 1'b1;
    tick();
    landed = 1'b0;
    tick();
    board = 32'hABADCDFA;
    tick();
    chk("t4_gen", 32'(state), 32'(GEN));
    chk("t4_nospawn", 32'(spawn), 32'd0);
    tick();
    chk("t4_over", 32'(state), 32'(OVR));
    chk("t4_gameover", 32'(game_over), 32'd1);
    chk("t4_spawn0", 32'(spawn), 32'd0);
    start_game("t4r");
    chk("t4r_gameover", 32'(game_over), 32'd0);

    // restart mid-MOVING
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_reset("t6m");
    m_lfsr = 8'hA5;
    q_piece.delete();
    start_game("t6s");

    // restart mid-CLEAR
    landed = 1'b1;
    tick();
    landed = 1'b0;
    tick();
    chk("t6_clear", 32'(state), 32'(CLR));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_reset("t6c");
    m_lfsr = 8'hA5;
    start_game("t6g");

    // accumulate to 8'hFE then saturate
    for (int i = 0; i < 36; i++) begin
      lock_cycle($sformatf("acc%0d", i), 32'h0FFFFFFF, 7);
    end
    lock_cycle("fe", 32'h0BAFFDCD, 2);
    chk("lines_fe", 32'(lines), 32'hFE);
    lock_cycle("sat", 32'h0BAFFDCD, 2);
    chk("lines_ff", 32'(lines), 32'hFF);
    lock_cycle("sat2", 32'h0FFFFFFF, 7);
    chk("lines_ff2", 32'(lines), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
